// File: rtl/mxv_uart_pkt_tx.sv
// MxV UART packet transmitter: frames FE | LEN | CMD | payload | EF and
// serialises each byte as start, 8 data LSB-first, parity, stop.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | line high, waiting for pkt_start
// START_BIT  | driving the start bit (0) of the current character
// DATA_BITS  | shifting out d[0]..d[7]
// PARITY_BIT | driving the parity bit
// STOP_BIT   | driving the stop bit (1); picks the next byte at its end
// WAIT_DATA  | payload byte needed but none held; line high, data_ready=1
module mxv_uart_pkt_tx #(
  parameter int WORD_LENGTH  = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_MODE  = 0,
  parameter int MAX_PAYLOAD  = 253
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pkt_start,
  input  logic [7:0]             pkt_cmd,
  input  logic [7:0]             pkt_len,
  input  logic [WORD_LENGTH-1:0] data_in,
  input  logic                   data_valid,
  output logic                   data_ready,
  output logic                   busy,
  output logic                   pkt_done,
  output logic                   pkt_err,
  output logic                   SerialOutputTx
);

  localparam logic [15:0] TIMER_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [7:0]  MAX_LEN      = 8'(MAX_PAYLOAD);
  localparam logic [7:0]  HDR_BYTE     = 8'hFE;
  localparam logic [7:0]  TRL_BYTE     = 8'hEF;

  typedef enum logic [2:0] {
    IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT, WAIT_DATA
  } state_t;

  typedef enum logic [2:0] {
    PH_HDR, PH_LEN, PH_CMD, PH_PAY, PH_TRL
  } phase_t;

  state_t      state, state_nxt;
  phase_t      phase, phase_nxt, phase_follow;

  logic [15:0] bit_timer;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_q;
  logic        par_q;
  logic        tx_q;
  logic [7:0]  cmd_q;
  logic [7:0]  len_q;
  logic [7:0]  pay_left;
  logic [7:0]  fetch_left;
  logic [7:0]  hold_data;
  logic        hold_full;

  logic        timer_tc;
  logic        xfer;
  logic        pay_avail;
  logic [7:0]  pay_byte;
  logic [7:0]  next_byte;
  logic [7:0]  char_byte;
  logic        char_load;
  logic        timer_load;
  logic        bit_adv;
  logic        hold_take;
  logic        pay_bypass;
  logic        accept;
  logic        reject;
  logic        done_nxt;
  logic        tx_nxt;

  function automatic logic parity_of(input logic [7:0] d);
    case (PARITY_MODE)
      1:       return ^d;
      2:       return ~^d;
      default: return 1'b1;
    endcase
  endfunction

  assign busy           = (state != IDLE);
  assign data_ready     = busy && !hold_full && (fetch_left != 8'd0);
  assign SerialOutputTx = tx_q;

  always_comb begin
    timer_tc  = (bit_timer == 16'd0);
    xfer      = data_valid && data_ready;
    pay_avail = hold_full || xfer;
    pay_byte  = hold_full ? hold_data : data_in;

    // pay_left counts payload characters not yet started
    case (phase)
      PH_HDR:         phase_follow = PH_LEN;
      PH_LEN:         phase_follow = PH_CMD;
      PH_CMD, PH_PAY: phase_follow = (pay_left != 8'd0) ? PH_PAY : PH_TRL;
      default:        phase_follow = PH_TRL;
    endcase

    case (phase_follow)
      PH_LEN:  next_byte = len_q + 8'd2;
      PH_CMD:  next_byte = cmd_q;
      PH_PAY:  next_byte = pay_byte;
      PH_TRL:  next_byte = TRL_BYTE;
      default: next_byte = HDR_BYTE;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    tx_nxt     = tx_q;
    char_load  = 1'b0;
    char_byte  = next_byte;
    timer_load = 1'b0;
    bit_adv    = 1'b0;
    hold_take  = 1'b0;
    pay_bypass = 1'b0;
    accept     = 1'b0;
    reject     = 1'b0;
    done_nxt   = 1'b0;

    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (pkt_start) begin
          if (pkt_len > MAX_LEN) begin
            reject = 1'b1;
          end else begin
            accept     = 1'b1;
            state_nxt  = START_BIT;
            phase_nxt  = PH_HDR;
            char_load  = 1'b1;
            char_byte  = HDR_BYTE;
            timer_load = 1'b1;
            tx_nxt     = 1'b0;
          end
        end
      end
      START_BIT: begin
        if (timer_tc) begin
          state_nxt  = DATA_BITS;
          tx_nxt     = shift_q[0];
          timer_load = 1'b1;
        end
      end
      DATA_BITS: begin
        if (timer_tc) begin
          timer_load = 1'b1;
          if (bit_idx == 3'd7) begin
            state_nxt = PARITY_BIT;
            tx_nxt    = par_q;
          end else begin
            bit_adv = 1'b1;
            tx_nxt  = shift_q[1];
          end
        end
      end
      PARITY_BIT: begin
        if (timer_tc) begin
          state_nxt  = STOP_BIT;
          tx_nxt     = 1'b1;
          timer_load = 1'b1;
        end
      end
      STOP_BIT: begin
        if (timer_tc) begin
          timer_load = 1'b1;
          if (phase == PH_TRL) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
            tx_nxt    = 1'b1;
          end else if (phase_follow != PH_PAY || pay_avail) begin
            // a byte arriving on this very edge goes straight to the shifter
            state_nxt = START_BIT;
            phase_nxt = phase_follow;
            char_load = 1'b1;
            tx_nxt    = 1'b0;
            if (phase_follow == PH_PAY) begin
              hold_take  = hold_full;
              pay_bypass = !hold_full;
            end
          end else begin
            state_nxt = WAIT_DATA;
            phase_nxt = PH_PAY;
            tx_nxt    = 1'b1;
          end
        end
      end
      WAIT_DATA: begin
        tx_nxt = 1'b1;
        if (xfer) begin
          state_nxt  = START_BIT;
          char_load  = 1'b1;
          char_byte  = data_in;
          timer_load = 1'b1;
          pay_bypass = 1'b1;
          tx_nxt     = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      phase <= PH_HDR;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_q       <= 1'b1;
      pkt_done   <= 1'b0;
      pkt_err    <= 1'b0;
      bit_timer  <= 16'd0;
      bit_idx    <= 3'd0;
      shift_q    <= 8'd0;
      par_q      <= 1'b1;
      cmd_q      <= 8'd0;
      len_q      <= 8'd0;
      pay_left   <= 8'd0;
      fetch_left <= 8'd0;
      hold_data  <= 8'd0;
      hold_full  <= 1'b0;
    end else begin
      tx_q     <= tx_nxt;
      pkt_done <= done_nxt;
      pkt_err  <= reject;

      if (timer_load) begin
        bit_timer <= TIMER_RELOAD;
      end else if (!timer_tc) begin
        bit_timer <= bit_timer - 16'd1;
      end

      if (accept) begin
        cmd_q      <= pkt_cmd;
        len_q      <= pkt_len;
        pay_left   <= pkt_len;
        fetch_left <= pkt_len;
      end else begin
        if (char_load && phase_nxt == PH_PAY) begin
          pay_left <= pay_left - 8'd1;
        end
        if (xfer) begin
          fetch_left <= fetch_left - 8'd1;
        end
      end

      if (char_load) begin
        shift_q <= char_byte;
        par_q   <= parity_of(char_byte);
        bit_idx <= 3'd0;
      end else if (bit_adv) begin
        shift_q <= {1'b0, shift_q[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end

      if (hold_take) begin
        hold_full <= 1'b0;
      end else if (xfer && !pay_bypass) begin
        hold_full <= 1'b1;
        hold_data <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_mxv_uart_pkt_tx.sv
// Bench for mxv_uart_pkt_tx: expected characters are queued when a packet is
// issued; a line decoder pops and compares each character it receives.
module tb_mxv_uart_pkt_tx;
  localparam int C    = 4;
  localparam int CHAR = 11 * C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [7:0] cmd0 = '0, len0 = '0, cmd1 = '0, len1 = '0;
  logic [7:0] din0 = '0;
  logic       dv0 = 1'b0;
  logic       dr0, busy0, done0, err0, tx0;
  logic       dr1, busy1, done1, err1, tx1;

  mxv_uart_pkt_tx #(.WORD_LENGTH(8), .CLKS_PER_BIT(C), .PARITY_MODE(0), .MAX_PAYLOAD(253)) dut0 (
    .clk(clk), .reset(reset), .pkt_start(start0), .pkt_cmd(cmd0), .pkt_len(len0),
    .data_in(din0), .data_valid(dv0), .data_ready(dr0), .busy(busy0),
    .pkt_done(done0), .pkt_err(err0), .SerialOutputTx(tx0));

  mxv_uart_pkt_tx #(.WORD_LENGTH(8), .CLKS_PER_BIT(C), .PARITY_MODE(1), .MAX_PAYLOAD(253)) dut1 (
    .clk(clk), .reset(reset), .pkt_start(start1), .pkt_cmd(cmd1), .pkt_len(len1),
    .data_in(8'h00), .data_valid(1'b0), .data_ready(dr1), .busy(busy1),
    .pkt_done(done1), .pkt_err(err1), .SerialOutputTx(tx1));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, want, want);
    end
  endtask

  // expected {parity, byte} per character, one queue per line
  logic [8:0] exp0[$];
  logic [8:0] exp1[$];

  task automatic push0(input logic [7:0] b);
    exp0.push_back({1'b1, b});
  endtask

  task automatic char_done(input int ch, input logic [10:0] b);
    logic [8:0] want;
    if ((ch == 0 && exp0.size() == 0) || (ch == 1 && exp1.size() == 0)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ch%0d unexpected chr: got 0x%0h, expected none", ch, b[8:1]);
    end else begin
      if (ch == 0) want = exp0.pop_front();
      else         want = exp1.pop_front();
      check($sformatf("ch%0d chr {stop,start,par,byte}", ch), int'({b[10], b[0], b[9], b[8:1]}),
            int'({2'b10, want}));
    end
  endtask

  logic       dec_busy [2];
  int         dec_cnt  [2];
  logic [10:0] dec_bits [2];
  logic       dec_flush = 1'b0;
  logic       ln;
  int         starts0[$];
  initial begin
    dec_busy[0] = 1'b0; dec_busy[1] = 1'b0;
    dec_cnt[0] = 0; dec_cnt[1] = 0;
  end

  always @(negedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      ln = (ch == 0) ? tx0 : tx1;
      if (ch == 0 && dec_flush) begin
        dec_busy[0] = 1'b0;
      end else if (!dec_busy[ch]) begin
        if (ln === 1'b0) begin
          dec_busy[ch] = 1'b1;
          dec_cnt[ch]  = 0;
          if (ch == 0) starts0.push_back(cyc);
        end
      end else begin
        dec_cnt[ch]++;
        if (dec_cnt[ch] % C == C / 2) begin
          dec_bits[ch][dec_cnt[ch] / C] = ln;
          if (dec_cnt[ch] / C == 10) begin
            dec_busy[ch] = 1'b0;
            char_done(ch, dec_bits[ch]);
          end
        end
      end
    end
  end

  int   done_cnt0 = 0, done_cyc0 = -1, err_cnt0 = 0;
  int   done_cnt1 = 0, done_cyc1 = -1;
  logic dr_seen0 = 1'b0;
  int   win_lo = -1, win_hi = -1, low_cnt = 0;
  always @(negedge clk) begin
    if (done0) begin done_cnt0++; done_cyc0 = cyc; end
    if (done1) begin done_cnt1++; done_cyc1 = cyc; end
    if (err0) err_cnt0++;
    if (dr0) dr_seen0 = 1'b1;
    if (cyc >= win_lo && cyc <= win_hi && tx0 !== 1'b1) low_cnt++;
  end

  // upstream payload source with an optional absolute stall window
  logic [7:0] pay_q[$];
  int   stall_lo = -1, stall_hi = -1;
  logic will_take = 1'b0;
  always @(negedge clk) begin
    if (will_take && pay_q.size() > 0) pay_q.delete(0);
    if (pay_q.size() > 0 && !((cyc + 1) >= stall_lo && (cyc + 1) <= stall_hi)) begin
      dv0  = 1'b1;
      din0 = pay_q[0];
    end else begin
      dv0 = 1'b0;
    end
    will_take = dv0 && dr0;
  end

  task automatic send(input int ch, input logic [7:0] c, input logic [7:0] n, output int t0);
    @(negedge clk);
    if (ch == 0) begin cmd0 = c; len0 = n; start0 = 1'b1; end
    else         begin cmd1 = c; len1 = n; start1 = 1'b1; end
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int ch, input int target, input int limit, input string name);
    int k;
    k = 0;
    while (((ch == 0) ? done_cnt0 : done_cnt1) < target && k < limit) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (((ch == 0) ? done_cnt0 : done_cnt1) < target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout, got no pkt_done, expected one within %0d clocks", name, limit);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin : main
    int t0;
    int d0;

    // reset state, and reset winning over a simultaneous pkt_start
    idle(3);
    check("reset {tx,busy,ready,done,err}", int'({tx0, busy0, dr0, done0, err0}), 5'b10000);
    @(negedge clk);
    start0 = 1'b1; len0 = 8'd0; cmd0 = 8'h55;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    reset  = 1'b0;
    idle(1);
    check("reset beats pkt_start {busy,tx}", int'({busy0, tx0}), 2'b01);

    // 1: one payload byte
    d0 = done_cnt0;
    push0(8'hFE); push0(8'h03); push0(8'h01); push0(8'h03); push0(8'hEF);
    pay_q.push_back(8'h03);
    send(0, 8'h01, 8'd1, t0);
    wait_done(0, d0 + 1, 400, "t1 done");
    check("t1 duration", done_cyc0 - t0, 5 * CHAR);
    idle(20);
    check("t1 done count", done_cnt0 - d0, 1);
    check("t1 chars left", exp0.size(), 0);

    // 2: empty payload, data_ready never raised
    d0 = done_cnt0;
    push0(8'hFE); push0(8'h02); push0(8'h03); push0(8'hEF);
    dr_seen0 = 1'b0;
    send(0, 8'h03, 8'd0, t0);
    wait_done(0, d0 + 1, 400, "t2 done");
    check("t2 duration", done_cyc0 - t0, 4 * CHAR);
    check("t2 data_ready seen", int'(dr_seen0), 0);
    idle(10);
    check("t2 chars left", exp0.size(), 0);

    // 3: nine bytes streamed back-to-back
    d0 = done_cnt0;
    push0(8'hFE); push0(8'h0B); push0(8'h04);
    for (int i = 0; i < 9; i++) begin push0(8'(i)); pay_q.push_back(8'(i)); end
    push0(8'hEF);
    starts0.delete();
    send(0, 8'h04, 8'd9, t0);
    wait_done(0, d0 + 1, 1000, "t3 done");
    check("t3 duration", done_cyc0 - t0, 13 * CHAR);
    check("t3 chr count", starts0.size(), 13);
    if (starts0.size() == 13) begin
      check("t3 first start", starts0[0] - t0, 0);
      for (int i = 1; i < 13; i++) check($sformatf("t3 gap %0d", i), starts0[i] - starts0[i-1], CHAR);
    end
    idle(10);
    check("t3 chars left", exp0.size(), 0);

    // 4: source stalls after byte 0x02 so the line underruns for 50 clocks
    d0 = done_cnt0;
    push0(8'hFE); push0(8'h0B); push0(8'h04);
    for (int i = 0; i < 9; i++) begin push0(8'(i)); pay_q.push_back(8'(i)); end
    push0(8'hEF);
    starts0.delete();
    low_cnt = 0;
    send(0, 8'h04, 8'd9, t0);
    stall_lo = t0 + 200;
    stall_hi = t0 + 6 * CHAR + 49;
    win_lo   = t0 + 6 * CHAR;
    win_hi   = t0 + 6 * CHAR + 49;
    wait_done(0, d0 + 1, 1200, "t4 done");
    check("t4 duration", done_cyc0 - t0, 13 * CHAR + 50);
    check("t4 line low in gap", low_cnt, 0);
    check("t4 chr count", starts0.size(), 13);
    if (starts0.size() == 13) begin
      check("t4 stalled chr start", starts0[6] - t0, 6 * CHAR + 50);
      check("t4 gap before stalled chr", starts0[6] - starts0[5], CHAR + 50);
      check("t4 gap after stalled chr", starts0[7] - starts0[6], CHAR);
    end
    idle(10);
    check("t4 chars left", exp0.size(), 0);
    stall_lo = -1; stall_hi = -1; win_lo = -1; win_hi = -1;

    // 5: oversize length rejected; pkt_start while busy ignored
    d0 = err_cnt0;
    @(negedge clk);
    len0 = 8'd254; cmd0 = 8'h06; start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    idle(1);
    check("t5 err pulse {err,busy,ready,tx}", int'({err0, busy0, dr0, tx0}), 4'b1001);
    idle(1);
    check("t5 err one cycle", int'(err0), 0);
    check("t5 err count", err_cnt0 - d0, 1);
    d0 = done_cnt0;
    push0(8'hFE); push0(8'h02); push0(8'h06); push0(8'hEF);
    send(0, 8'h06, 8'd0, t0);
    idle(60);
    @(negedge clk);
    cmd0 = 8'h07; len0 = 8'd0; start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    wait_done(0, d0 + 1, 400, "t5 done");
    check("t5 duration", done_cyc0 - t0, 4 * CHAR);
    idle(250);
    check("t5 done count", done_cnt0 - d0, 1);
    check("t5 busy after", int'(busy0), 0);
    check("t5 chars left", exp0.size(), 0);

    // 6: reset during the third payload character, then fresh packets
    d0 = done_cnt0;
    push0(8'hFE); push0(8'h07); push0(8'h09); push0(8'h10); push0(8'h11);
    for (int i = 0; i < 5; i++) pay_q.push_back(8'(8'h10 + i));
    send(0, 8'h09, 8'd5, t0);
    while (cyc < t0 + 5 * CHAR + 19) begin
      @(negedge clk);
      #1;
    end
    dec_flush = 1'b1;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    pay_q.delete();
    idle(1);
    check("t6 after reset {tx,busy,ready}", int'({tx0, busy0, dr0}), 3'b100);
    idle(2);
    dec_flush = 1'b0;
    idle(300);
    check("t6 no done after abort", done_cnt0 - d0, 0);
    check("t6 chars before abort", exp0.size(), 0);

    d0 = done_cnt0;
    push0(8'hFE); push0(8'h02); push0(8'h05); push0(8'hEF);
    send(0, 8'h05, 8'd0, t0);
    wait_done(0, d0 + 1, 400, "t6 recover done");
    check("t6 recover duration", done_cyc0 - t0, 4 * CHAR);

    exp1.push_back({1'b1, 8'hFE});
    exp1.push_back({1'b1, 8'h02});
    exp1.push_back({1'b0, 8'h05});
    exp1.push_back({1'b1, 8'hEF});
    send(1, 8'h05, 8'd0, t0);
    wait_done(1, 1, 400, "t6 even done");
    check("t6 even duration", done_cyc1 - t0, 4 * CHAR);
    idle(20);
    check("t6 even chars left", exp1.size(), 0);
    check("final ch0 chars left", exp0.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mxv_uart_pkt_tx.md
Name: mxv_uart_pkt_tx

Overview:
Transmit side of the MxV UART link. Takes a command byte and a stream of payload bytes from the result path and builds a framed packet: 0xFE header, length, command, payload, 0xEF trailer. Each byte is sent as one UART character: start, 8 data bits LSB-first, parity bit, stop. The line format matches what P3 expects on SerialDataRx, so the two ends are symmetric.

Parameters:
WORD_LENGTH, 8, payload/data byte width; only 8 is supported.
CLKS_PER_BIT, 434, clocks per UART bit (115200 baud at 50 MHz); legal range 2..65535.
PARITY_MODE, 0, 0 = parity bit always 1 (current link format), 1 = even, 2 = odd.
MAX_PAYLOAD, 253, largest accepted pkt_len; the length byte N+2 must fit in 8 bits.

Ports:
clk  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
pkt_start  in  1  one-cycle request to send a packet; sampled only while busy=0.
pkt_cmd  in  8  command byte; captured when pkt_start is accepted.
pkt_len  in  8  payload byte count N (0..MAX_PAYLOAD); captured when pkt_start is accepted.
data_in  in  WORD_LENGTH  payload byte.
data_valid  in  1  data_in is valid.
data_ready  out  1  block can accept a payload byte; a transfer occurs on data_valid&&data_ready.
busy  out  1  a packet is in progress.
pkt_done  out  1  one-cycle pulse when the trailer stop bit completes.
pkt_err  out  1  one-cycle pulse when pkt_start is rejected because pkt_len>MAX_PAYLOAD.
SerialOutputTx  out  1  UART line, registered; idle level is 1.

Behaviour:
- Reset values:
  - SerialOutputTx=1; busy, data_ready, pkt_done, pkt_err all 0.
  - Holding register empty; FSM in IDLE.
  - Reset applied mid-packet aborts the packet at that edge (no trailer, no pkt_done). The line is 1 from the next edge.
- Wire order:
  - 0xFE, then LEN = N+2 (mod-free, since N≤253), then pkt_cmd, then N payload bytes in accept order, then 0xEF.
  - LEN counts every byte after itself, including 0xEF.
- Character format:
  - Sequence: start(0), d[0]..d[7], parity, stop(1); 11 bits.
  - Each bit is held for exactly CLKS_PER_BIT clocks; the bit counter reloads on every bit boundary.
  - Parity bit: mode 0 → 1; mode 1 → ^d; mode 2 → ~^d.
- FSM states:
  - IDLE: line=1. Accepted pkt_start → START_BIT (first start bit driven at that same edge), busy=1.
  - START_BIT → DATA_BITS (8) → PARITY_BIT → STOP_BIT.
  - At the end of STOP_BIT:
    - If bytes remain and the next byte is available (constant byte, or holding register full), go straight to START_BIT. There is no idle gap.
    - If the next byte is payload and the holding register is empty, go to WAIT_DATA.
    - If the trailer is done, go to IDLE with pkt_done=1 and busy=0 on that edge.
  - WAIT_DATA: line=1, data_ready=1. On transfer → START_BIT at the next edge.
- Byte sequencing: a phase counter steps HDR → LEN → CMD → PAY (8-bit down-counter from N) → TRL. When N=0, CMD goes directly to TRL.
- Payload prefetch:
  - One-byte holding register.
  - data_ready=1 while busy, the holding register is empty, and un-fetched payload bytes remain; this lets upstream fill it during any earlier character.
  - data_ready=0 in IDLE and after the last payload byte has been accepted. Bytes offered when data_ready=0 are ignored.
- pkt_start:
  - Ignored while busy=1, including during WAIT_DATA.
  - Accepted in the same cycle pkt_done is high, because busy is already 0.
  - If pkt_len>MAX_PAYLOAD: pkt_err pulses, busy stays 0, the line stays 1.
- Simultaneous reset and pkt_start: reset wins.
- Duration with no underrun: (N+4)·11·CLKS_PER_BIT clocks, from the edge that accepts pkt_start to pkt_done.

Test Plan:
1. CLKS_PER_BIT=4, PARITY_MODE=0; pkt_start with cmd=0x01, len=1; data 0x03 held valid → decoded line: FE 03 01 03 EF, parity bits all 1. pkt_done exactly once, 220 clocks after start.
2. cmd=0x03, len=0 → FE 02 03 EF with data_ready never high. pkt_done 176 clocks after start.
3. cmd=0x04, len=9, payload 00..08 streamed with data_valid constantly 1 → FE 0B 04 00 01 02 03 04 05 06 07 08 EF, with no idle clock between characters.
4. Same as scenario 3, but data_valid dropped for 50 clocks after byte 0x02 → line held at 1 during the gap with no spurious start bit. Remaining bytes are correct; duration grows by exactly the stall length.
5. pkt_len=254 → pkt_err one cycle; busy, data_ready and SerialOutputTx unchanged. pkt_start pulsed while busy → ignored, no second packet.
6. reset asserted during the 3rd payload character → next edge: line=1, busy=0, data_ready=0, no pkt_done. Following packet cmd=0x05, len=0, PARITY_MODE=1 → FE 02 05 EF with even-parity bits 1,1,0,1.
